// File: rtl/vga_plot_sink_if.sv
// vga_plot_sink_if: pixel plot bus plus framebuffer write port and debug status
interface vga_plot_sink_if;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot;
  logic        clear;
  logic        busy;
  logic [14:0] mem_addr;
  logic [2:0]  mem_data;
  logic        mem_we;
  logic        mem_ready;
  logic [7:0]  dropped_count;
  logic        oob;
  modport master (
    output x, y, colour, plot, clear, mem_ready,
    input  busy, mem_addr, mem_data, mem_we, dropped_count, oob
  );
  modport slave (
    input  x, y, colour, plot, clear, mem_ready,
    output busy, mem_addr, mem_data, mem_we, dropped_count, oob
  );
endinterface

// File: rtl/vga_plot_sink.sv
// vga_plot_sink: buffers plot strobes in a FIFO and issues framebuffer write beats,
// including a full-screen clear to BG_COLOR and drop/out-of-range debug status.
module vga_plot_sink #(
  parameter int         WIDTH      = 160,
  parameter int         HEIGHT     = 120,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [2:0] BG_COLOR   = 3'b000
) (
  input logic            clock,
  input logic            reset,
  vga_plot_sink_if.slave bus
);
  localparam int          AW    = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH = (AW + 1)'(FIFO_DEPTH);
  localparam logic [14:0] LAST  = 15'(WIDTH * HEIGHT - 1);
  typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;
  state_t        state_q, state_d;
  logic [17:0]   fifo_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [14:0]   addr_q, addr_d;
  logic [2:0]    data_q, data_d;
  logic [7:0]    drop_q, drop_d;
  logic          we_q, we_d, cp_q, cp_d, oob_q, oob_d;
  logic          in_range, full, push, pop, accept, go, cp_now;
  logic [17:0]   head;
  assign in_range = ({1'b0, bus.x} < 9'(WIDTH)) && ({1'b0, bus.y} < 8'(HEIGHT));
  assign full     = cnt_q == DEPTH;
  assign push     = bus.plot && in_range && !full;
  assign head     = fifo_q[rptr_q];
  assign accept   = we_q && bus.mem_ready;
  // go: the output register is free to take a new beat this cycle
  assign go       = state_q == IDLE || (accept && (state_q == WRITE || addr_q == LAST));
  assign cp_now   = state_q != CLEAR && cp_q;
  assign pop      = go && !cp_now && cnt_q != '0;
  always_comb begin
    state_d = !go ? state_q : cp_now ? CLEAR : pop ? WRITE : IDLE;
    addr_d  = !go ? ((state_q == CLEAR && accept) ? addr_q + 15'd1 : addr_q)
            : cp_now ? 15'd0
            : pop ? 15'(head[9:3]) * 15'(WIDTH) + 15'(head[17:10]) : addr_q;
    data_d  = !go ? data_q : cp_now ? BG_COLOR : pop ? head[2:0] : data_q;
    we_d    = go ? (cp_now || pop) : we_q;
    cp_d    = state_q == CLEAR ? !(accept && addr_q == LAST) : (cp_q || bus.clear);
    cnt_d   = cnt_q + (AW + 1)'(push) - (AW + 1)'(pop);
    wptr_d  = wptr_q + AW'(push);
    rptr_d  = rptr_q + AW'(pop);
    oob_d   = oob_q || (bus.plot && !in_range);
    drop_d  = drop_q + 8'(bus.plot && in_range && full && drop_q != 8'hff);
  end
  always_ff @(posedge clock)
    if (push) fifo_q[wptr_q] <= {bus.x, bus.y, bus.colour};
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      cp_q    <= 1'b0;
      oob_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      cp_q    <= cp_d;
      oob_q   <= oob_d;
      drop_q  <= drop_d;
    end
  assign bus.busy          = full || state_q == CLEAR;
  assign bus.mem_addr      = addr_q;
  assign bus.mem_data      = data_q;
  assign bus.mem_we        = we_q;
  assign bus.dropped_count = drop_q;
  assign bus.oob           = oob_q;
endmodule
